reg_file: RTL and testbench
===========================

# reg_file

Architectural register file for the single-cycle core: 32 × N-bit general-purpose registers with two asynchronous read ports that drive the ALU `A`/`B` operands and one synchronous write port fed by the ALU `result`. It also holds a 4-bit condition-flag register that captures the ALU `flags` output (`{CARRY, 0, SIGN, ZERO}`) for the branch logic. After reset, a sequential clear sweep zeroes every entry, so the storage can map to distributed RAM with no per-bit reset. `ready` stays low until the sweep completes.

## Interface
- `N`, default 32: data width; matches ALU operand width.
- `DEPTH`, fixed at 32: number of registers; address width is 5.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rs1_addr`  in  5  read port 1 address.
- `rs2_addr`  in  5  read port 2 address.
- `rs1_data`  out  N  read port 1 data; drives ALU `A`.
- `rs2_data`  out  N  read port 2 data; drives ALU `B`.
- `we`  in  1  write enable for the `rd` port.
- `rd_addr`  in  5  write address.
- `rd_data`  in  N  write data; driven from ALU `result`.
- `flags_we`  in  1  capture enable for the flag register.
- `flags_in`  in  4  ALU `flags` `{CARRY, 0, SIGN, ZERO}`.
- `flags_q`  out  4  registered flags; bit 2 is always 0.
- `ready`  out  1  high when the sweep is done and the block accepts writes.

## Operation
- Two states: INIT (clear sweep) and RUN.
- Reset: on any rising edge with `rst_n`=0:
  - state ← INIT, `clr_ptr` ← 1, `ready` ← 0, `flags_q` ← 0.
  - Array contents are not touched during reset.
- INIT, with `rst_n`=1:
  - Each cycle, write 0 to entry `clr_ptr`, then increment `clr_ptr`.
  - When `clr_ptr`=31 is written, move to RUN and set `ready` ← 1 on that same edge.
  - `we` and `flags_we` are ignored throughout INIT.
  - `rs1_data` and `rs2_data` are forced to 0.
- RUN:
  - When `we`=1 and `rd_addr`≠0, entry `rd_addr` ← `rd_data` at the clock edge.
  - When `flags_we`=1, `flags_q` ← `{flags_in[3], 1'b0, flags_in[1:0]}`.
- x0:
  - Has no physical storage.
  - A read of address 0 always returns 0 in both states.
  - A write to address 0 is discarded silently.
- Reads are combinational from the array (single-cycle datapath). There is no write-to-read bypass.
- Reset in the middle of INIT restarts the sweep at `clr_ptr`=1. Reset in RUN re-enters INIT, and all registers become 0 again after the sweep.
- `clr_ptr` is 5 bits wide and never wraps. The INIT→RUN transition happens at the value 31.

## Timing
- Reset values: `ready`=0, `flags_q`=4'b0000, `rs1_data`=`rs2_data`=0.
- Sweep length: 31 cycles. With `rst_n` released before edge E0, entries 1..31 are cleared on edges E0..E30, and `ready` is observed high after E30.
- Read latency: 0 cycles. The address change propagates to data within the same cycle.
- Write latency: 1 edge.
  - A read of `rd_addr` in the same cycle as its write returns the old value.
  - The new value appears after the edge.
- Flag capture: 1 edge. `flags_q` holds its value when `flags_we`=0.
- Simultaneous `we`, `flags_we` and reads in one cycle are fully independent.

## Test plan
- **Reset sweep:** hold `rst_n`=0 for 2 cycles, then release.
  - `ready`=0 for exactly 31 edges, then 1.
  - Afterwards, reading every address 0..31 returns 0.
- **Write/read and x0:**
  - Write 0xDEADBEEF to x5 and 0x12345678 to x0.
  - With `rs1_addr`=5 and `rs2_addr`=0, the bench sees `rs1_data`=0xDEADBEEF and `rs2_data`=0.
- **Same-cycle hazard:**
  - Preload x7=0x11; drive `we`=1, `rd_addr`=7, `rd_data`=0x22 with `rs1_addr`=7.
  - `rs1_data`=0x11 before the edge and 0x22 after it.
- **Writes ignored in INIT:**
  - Assert `we`=1 with x3=0xFF and `flags_we`=1 with `flags_in`=4'hF during the sweep.
  - After `ready`: x3 reads 0 and `flags_q`=0.
- **Flag capture:**
  - In RUN, `flags_we`=1 with `flags_in`=4'b1111 gives `flags_q`=4'b1011.
  - With `flags_we`=0 and `flags_in`=0, `flags_q` holds 4'b1011.
- **Reset mid-operation:**
  - Write x9=0xA5, then assert reset at sweep cycle 10.
  - The sweep restarts, `ready` rises 31 edges after release, and x9 reads 0.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 32 x N architectural registers with two async read ports, one sync write port and a 4-bit flag register.
// A post-reset clear sweep zeroes entries 1..31, so the storage needs no per-bit reset; ready rises when the sweep ends.
module reg_file #(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  output logic [N-1:0] rs1_data,
  output logic [N-1:0] rs2_data,
  input  logic         we,
  input  logic [4:0]   rd_addr,
  input  logic [N-1:0] rd_data,
  input  logic         flags_we,
  input  logic [3:0]   flags_in,
  output logic [3:0]   flags_q,
  output logic         ready
);

  typedef enum logic {INIT, RUN} state_e;

  state_e      state_q;
  logic [4:0]  clr_ptr_q;

  // Entry 0 is never written and every read of it is masked, so it is pruned away.
  logic [N-1:0] mem_q [DEPTH];

  logic         mem_we_d;
  logic [4:0]   mem_waddr_d;
  logic [N-1:0] mem_wdata_d;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = rd_addr;
    mem_wdata_d = rd_data;
    if (rst_n) begin
      if (state_q == INIT) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = clr_ptr_q;
        mem_wdata_d = '0;
      end else begin
        mem_we_d = we && (rd_addr != 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_ptr_q <= 5'd1;
      ready     <= 1'b0;
      flags_q   <= 4'b0000;
    end else begin
      case (state_q)
        INIT: begin
          if (clr_ptr_q == 5'd31) begin
            state_q <= RUN;
            ready   <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + 5'd1;
          end
        end
        RUN: begin
          // Bit 2 of the ALU flags is a constant 0 slot; mask it off.
          if (flags_we) begin
            flags_q <= flags_in & 4'b1011;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rs1_data = (state_q == RUN && rs1_addr != 5'd0) ? mem_q[rs1_addr] : '0;
  assign rs2_data = (state_q == RUN && rs2_addr != 5'd0) ? mem_q[rs2_addr] : '0;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        we, flags_we;
  logic [3:0]  flags_in, flags_q;
  logic        ready;

  reg_file #(.N(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .flags_we(flags_we), .flags_in(flags_in), .flags_q(flags_q),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural register values, flags, readiness.
  logic [31:0] m_reg [32];
  logic [3:0]  m_flags;
  bit          m_ready;
  int          m_edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (m_ready && a != 0) ? m_reg[a] : 32'd0;
  endfunction

  // One rising edge; the model consumes the inputs that were stable at it.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_ready = 0;
      m_edges = 0;
      m_flags = 4'd0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == 31) begin
        m_ready = 1;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      end
    end else begin
      if (we && rd_addr != 0) m_reg[rd_addr] = rd_data;
      if (flags_we) m_flags = {flags_in[3], 1'b0, flags_in[1:0]};
    end
    #1;
  endtask

  task automatic idle();
    we = 0; flags_we = 0; flags_in = 4'd0; rd_addr = 5'd0; rd_data = 32'd0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1; rd_addr = a; rd_data = d;
    step();
    we = 0;
  endtask

  // Steps until ready (bounded) and returns the number of edges taken.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!ready && edges < 40) begin
      step();
      edges++;
      check("ready_track", {31'd0, ready}, {31'd0, m_ready});
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      check({tag, "_rs1"}, rs1_data, m_read(rs1_addr));
      check({tag, "_rs2"}, rs2_data, m_read(rs2_addr));
    end
  endtask

  int edges;

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = 32'hx;
    m_flags = 4'd0; m_ready = 0; m_edges = 0;
    rst_n = 0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    idle();

    // Reset state
    step(); step();
    rs1_addr = 5'd4; rs2_addr = 5'd9; #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    check("rst_rs1", rs1_data, 32'd0);
    check("rst_rs2", rs2_data, 32'd0);

    // Sweep with writes/flags attempted during INIT
    rst_n = 1;
    we = 1; rd_addr = 5'd3; rd_data = 32'hFF; flags_we = 1; flags_in = 4'hF;
    rs1_addr = 5'd3; #1;
    check("init_rs1_forced0", rs1_data, 32'd0);
    wait_ready(edges);
    check("sweep_len", 32'(edges), 32'd31);
    idle();
    #1;
    check("init_flags_ignored", {28'd0, flags_q}, 32'd0);
    rs1_addr = 5'd3; #1;
    check("init_x3_ignored", rs1_data, 32'd0);
    check_all_regs("swept");

    // Write/read and x0
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd0, 32'h12345678);
    rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
    check("x5_read", rs1_data, 32'hDEADBEEF);
    check("x0_read", rs2_data, 32'd0);

    // Same-cycle hazard: no bypass
    write_reg(5'd7, 32'h11);
    we = 1; rd_addr = 5'd7; rd_data = 32'h22; rs1_addr = 5'd7; #1;
    check("hazard_before", rs1_data, 32'h11);
    step();
    we = 0; #1;
    check("hazard_after", rs1_data, 32'h22);

    // Flag capture and hold
    flags_we = 1; flags_in = 4'b1111; step();
    check("flags_capture", {28'd0, flags_q}, 32'hB);
    flags_we = 0; flags_in = 4'b0000; step();
    check("flags_hold", {28'd0, flags_q}, 32'hB);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      we       = ($urandom_range(0, 3) != 0);
      rd_addr  = 5'($urandom_range(0, 31));
      rd_data  = $urandom;
      flags_we = ($urandom_range(0, 2) == 0);
      flags_in = 4'($urandom_range(0, 15));
      rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      check("rnd_rs1", rs1_data, m_read(rs1_addr));
      check("rnd_rs2", rs2_data, m_read(rs2_addr));
      step();
      check("rnd_flags", {28'd0, flags_q}, {28'd0, m_flags});
      check("rnd_ready", {31'd0, ready}, {31'd0, m_ready});
    end
    idle();
    check_all_regs("rnd_final");

    // Reset in RUN, then again mid-sweep
    write_reg(5'd9, 32'hA5);
    rst_n = 0; step(); step();
    check("rerun_ready_low", {31'd0, ready}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) step();
    rst_n = 0; step();
    check("mid_rst_flags", {28'd0, flags_q}, 32'd0);
    rst_n = 1;
    wait_ready(edges);
    check("resweep_len", 32'(edges), 32'd31);
    rs1_addr = 5'd9; rs2_addr = 5'd5; #1;
    check("x9_cleared", rs1_data, 32'd0);
    check("x5_cleared", rs2_data, 32'd0);
    check_all_regs("resweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
